tl_ul_initiator: RTL and testbench
==================================

TL_UL_INITIATOR -- requirements
Module: tl_ul_initiator

Interface
REQ-001 The block SHALL have parameter SOURCE_ID, default 0, the 9-bit A-channel source value.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, the D-channel wait limit in cycles (range 2..65535).
REQ-003 The block SHALL have one clock and asynchronous active-high reset: clock  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-004 The block SHALL have the command port: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write); cmd_addr in 32; cmd_size in 2 (log2 bytes); cmd_wdata in 32.
REQ-005 The block SHALL have the A port: a_valid out 1; a_ready in 1; a_opcode out 3; a_param out 3; a_size out 2; a_source out 9; a_address out 32; a_mask out 4; a_data out 32.
REQ-006 The block SHALL have the D port: d_valid in 1; d_ready out 1; d_opcode in 3; d_param in 2; d_size in 2; d_source in 9; d_denied in 1; d_data in 32; d_corrupt in 1.
REQ-007 The block SHALL have the response port: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32; rsp_error out 1; rsp_timeout out 1.

Function
REQ-008 The FSM SHALL have states IDLE, AREQ, DWAIT, RESP; one transaction outstanding at most.
REQ-009 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready captures all cmd fields and moves to AREQ.
REQ-010 A misaligned command (cmd_addr not a multiple of 2^cmd_size, or cmd_size=3) SHALL skip AREQ/DWAIT, go to RESP with rsp_error=1, rsp_rdata=0, no A beat.
REQ-011 In AREQ a_valid SHALL be 1 with stable fields until a_ready; a_ready in the same cycle a_valid rises SHALL complete the beat and move to DWAIT.
REQ-012 a_opcode SHALL be 4 (Get) for reads, 0 (PutFullData) for writes; a_param=0; a_source=SOURCE_ID; a_size=captured size.
REQ-013 a_mask SHALL be the byte lanes covered by size and addr[1:0] (size0: one bit; size1: 0011/1100; size2: 1111); a_data = captured wdata for writes, 0 for reads.
REQ-014 d_ready SHALL be 1 only in DWAIT; a D beat is accepted on d_valid&d_ready.
REQ-015 On acceptance, rsp_error SHALL be d_denied | d_corrupt | (d_source != SOURCE_ID) | (expected opcode mismatch: AccessAckData=1 for reads, AccessAck=0 for writes); rsp_rdata = d_data for error-free reads, else 0.
REQ-016 RESP SHALL hold rsp_valid=1 and stable data until rsp_ready, then return to IDLE; earliest next cmd_ready is the following cycle.
REQ-017 A d_valid outside DWAIT SHALL be ignored (d_ready=0), not flagged.
REQ-018 Minimum latency cmd accept -> rsp_valid SHALL be 3 cycles with a_ready and d_valid held high.

Reset
REQ-019 Reset SHALL force IDLE immediately; outputs: cmd_ready=1 after reset release, a_valid=0, d_ready=0, rsp_valid=0, rsp_error=0, rsp_timeout=0, all data/address outputs 0.
REQ-020 Reset mid-transaction SHALL abandon it with no response; a later stray D beat is ignored per REQ-017.

Configuration
REQ-021 Macro TL_UL_INITIATOR_TIMEOUT_EN: defined -> a 16-bit counter clears on DWAIT entry, increments each DWAIT cycle; reaching TIMEOUT_CYCLES moves to RESP with rsp_error=1, rsp_timeout=1, rsp_rdata=0, and a late D beat is then ignored.
REQ-022 Without TL_UL_INITIATOR_TIMEOUT_EN, no counter SHALL exist, DWAIT waits indefinitely, rsp_timeout is tied 0.

Structure
REQ-023 Shared package tl_ul_pkg SHALL hold A/D opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1), field widths (address 32, data 32, source 9, size 2), and the FSM state enum.
REQ-024 Mask generation SHALL be sub-module tl_ul_mask_gen (size, addr[1:0] -> mask), combinational, reused by future TL-UL blocks.

Verification
REQ-025 Read: cmd addr=0x1000 size=2 read, a_ready=1, D AccessAckData data=0xDEADBEEF source=0 -> A Get mask=1111, rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid 3 cycles after cmd.
REQ-026 Byte write: addr=0x2003 size=0 wdata=0x000000AB -> PutFullData mask=1000; AccessAck -> rsp_error=0.
REQ-027 Error paths: d_denied=1 -> rsp_error=1, rsp_rdata=0; read answered with AccessAck -> rsp_error=1; d_source=5 -> rsp_error=1.
REQ-028 Misaligned: addr=0x1002 size=2 -> no a_valid, rsp_error=1 next cycle.
REQ-029 Backpressure/reset: a_ready low 10 cycles -> A fields stable; rsp_ready low 5 cycles -> rsp stable; reset asserted in DWAIT -> IDLE, later D beat ignored.
REQ-030 With TL_UL_INITIATOR_TIMEOUT_EN, TIMEOUT_CYCLES=8, no D beat -> rsp_timeout=1, rsp_error=1 after 8 DWAIT cycles.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcode constants, field widths, initiator
// FSM state encoding and an alignment helper.
package tl_ul_pkg;

    localparam int unsigned TL_AW   = 32;
    localparam int unsigned TL_DW   = 32;
    localparam int unsigned TL_SRCW = 9;
    localparam int unsigned TL_SZW  = 2;

    // A-channel opcodes
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] A_PUT_FULL      = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AREQ  = 2'd1,
        DWAIT = 2'd2,
        RESP  = 2'd3
    } tl_state_e;

    // True when the low address bits are a multiple of 2^size on a 32-bit bus.
    // size 3 (8 bytes) can never be carried and is reported as misaligned.
    function automatic logic tl_is_aligned(input logic [TL_SZW-1:0] size,
                                           input logic [1:0]        addr_lo);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (addr_lo[0] == 1'b0);
            2'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_ul_mask_gen.sv
// TileLink-UL byte-lane mask generator for a 32-bit data bus.
// Purely combinational; expects an aligned (size, addr_lo) pair.
module tl_ul_mask_gen
    import tl_ul_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);

    // Select the byte lanes covered by the access
    always_comb begin
        mask = 4'b0000;
        case (size)
            2'd0:    mask = 4'b0001 << addr_lo;
            2'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

endmodule

// File: rtl/tl_ul_initiator.sv
// Single-outstanding TileLink-UL initiator: turns one command into one A beat,
// waits for the matching D beat and returns a checked response.
// Optional feature: define TL_UL_INITIATOR_TIMEOUT_EN to bound the D-channel
// wait to TIMEOUT_CYCLES cycles; otherwise DWAIT waits indefinitely.
module tl_ul_initiator
    import tl_ul_pkg::*;
#(
    parameter int unsigned SOURCE_ID      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    // A channel
    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_param,
    output logic [1:0]  a_size,
    output logic [8:0]  a_source,
    output logic [31:0] a_address,
    output logic [3:0]  a_mask,
    output logic [31:0] a_data,
    // D channel
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [1:0]  d_param,
    input  logic [1:0]  d_size,
    input  logic [8:0]  d_source,
    input  logic        d_denied,
    input  logic [31:0] d_data,
    input  logic        d_corrupt,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout
);

    localparam logic [TL_SRCW-1:0] SRC = TL_SRCW'(SOURCE_ID);

    tl_state_e   state;
    tl_state_e   state_nxt;

    logic        cmd_fire;
    logic        cmd_misaligned;
    logic        d_fire;
    logic        tmo_fire;
    logic        tmo_expired;
    logic        d_err;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [3:0]  mask;

    // Only the opcode, source and status bits of a D beat matter here.
    logic        unused_d_fields;
    assign unused_d_fields = ^{d_param, d_size};

    assign cmd_misaligned = !tl_is_aligned(cmd_size, cmd_addr[1:0]);

    // Expected D opcode depends on the captured direction of the request.
    assign d_err = d_denied | d_corrupt | (d_source != SRC) |
                   (d_opcode != (wr_q ? D_ACCESS_ACK : D_ACCESS_ACK_DATA));

    tl_ul_mask_gen u_mask_gen (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .mask    (mask)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        a_valid   = 1'b0;
        d_ready   = 1'b0;
        rsp_valid = 1'b0;
        cmd_fire  = 1'b0;
        d_fire    = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire  = 1'b1;
                    state_nxt = cmd_misaligned ? RESP : AREQ;
                end
            end
            AREQ: begin
                a_valid = 1'b1;
                if (a_ready) begin
                    state_nxt = DWAIT;
                end
            end
            DWAIT: begin
                d_ready = 1'b1;
                if (d_valid) begin
                    d_fire    = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_expired) begin
                    tmo_fire  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture command fields on acceptance; held stable for the whole A beat
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            size_q  <= cmd_size;
            wdata_q <= cmd_wdata;
        end
    end

    // Response read data: D data only for an error-free read, else zero
    always_ff @(posedge clk) begin
        if (cmd_fire || tmo_fire) begin
            rdata_q <= 32'd0;
        end else if (d_fire) begin
            rdata_q <= (!wr_q && !d_err) ? d_data : 32'd0;
        end
    end

    // Response error flag, decided at whichever event enters RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cmd_fire) begin
            err_q <= cmd_misaligned;
        end else if (d_fire) begin
            err_q <= d_err;
        end else if (tmo_fire) begin
            err_q <= 1'b1;
        end
    end

`ifdef TL_UL_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_q;

    // Count DWAIT cycles; held at zero elsewhere so every DWAIT entry starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 16'd0;
        end else if (state != DWAIT) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_expired = (state == DWAIT) && (tmo_cnt == TMO_LAST);

    // Timeout flag for the pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else if (cmd_fire || d_fire) begin
            tmo_q <= 1'b0;
        end else if (tmo_fire) begin
            tmo_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_valid & tmo_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
    assign tmo_expired = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // A channel fields are driven only while the beat is offered
    assign a_opcode  = a_valid ? (wr_q ? A_PUT_FULL : A_GET) : 3'd0;
    assign a_param   = 3'd0;
    assign a_size    = a_valid ? size_q : 2'd0;
    assign a_source  = a_valid ? SRC : 9'd0;
    assign a_address = a_valid ? addr_q : 32'd0;
    assign a_mask    = a_valid ? mask : 4'd0;
    assign a_data    = (a_valid && wr_q) ? wdata_q : 32'd0;

    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_tl_ul_initiator.sv
// Self-checking bench for tl_ul_initiator (scoreboard of expected A beats and
// responses). Define TL_UL_INITIATOR_TIMEOUT_EN to exercise the timeout path.
module tb_tl_ul_initiator;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [8:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } a_beat_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [8:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param, d_size;
    logic [8:0]  d_source;
    logic        d_denied, d_corrupt;
    logic [31:0] d_data;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    a_beat_t exp_a_q[$];
    rsp_t    exp_rsp_q[$];

    a_beat_t obs_a;
    rsp_t    obs_rsp;
    int      obs_lat;
    int      obs_a_cycles;
    int      obs_a_beats;
    bit      obs_a_stable;
    bit      obs_rsp_stable;

    tl_ul_initiator #(.SOURCE_ID(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    function automatic a_beat_t cur_a();
        a_beat_t b;
        b.op = a_opcode; b.param = a_param; b.size = a_size; b.src = a_source;
        b.addr = a_address; b.mask = a_mask; b.data = a_data;
        return b;
    endfunction

    // Reference mask: lanes lo .. lo+2^size-1
    function automatic logic [3:0] mk_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        int n;
        n = 1 << size;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= int'(lo) && i < int'(lo) + n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic a_beat_t mk_beat(input logic wr, input logic [31:0] addr,
                                        input logic [1:0] size, input logic [31:0] wdata);
        a_beat_t b;
        b.op = wr ? 3'd0 : 3'd4; b.param = 3'd0; b.size = size; b.src = 9'd0;
        b.addr = addr; b.mask = mk_mask(size, addr[1:0]); b.data = wr ? wdata : 32'd0;
        return b;
    endfunction

    function automatic rsp_t mk_rsp(input logic wr, input logic [2:0] dop, input logic [8:0] dsrc,
                                    input logic dden, input logic dcor, input logic [31:0] ddata);
        rsp_t r;
        r.err   = dden | dcor | (dsrc != 9'd0) | (dop != (wr ? 3'd0 : 3'd1));
        r.rdata = (!wr && !r.err) ? ddata : 32'd0;
        r.tmo   = 1'b0;
        return r;
    endfunction

    // Drive one command and serve the A, D and response handshakes.
    // d_delay: 0 = d_valid held high from the start, >0 = DWAIT cycles before
    // d_valid, <0 = never. Ends #1 after the response handshake edge.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input int a_delay, input int r_delay,
                       input int d_delay, input logic [2:0] dop, input logic [8:0] dsrc,
                       input logic dden, input logic dcor, input logic [31:0] ddata);
        int a_wait, r_wait, d_wait;
        bit done, a_seen, rsp_seen;
        rsp_t cur_r;
        obs_a = 'x; obs_rsp = 'x; obs_lat = -1;
        obs_a_cycles = 0; obs_a_beats = 0; obs_a_stable = 1; obs_rsp_stable = 1;
        a_seen = 0; rsp_seen = 0; done = 0; a_wait = 0; r_wait = 0; d_wait = 0;
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata; cmd_valid = 1'b1;
        a_ready = (a_delay == 0);
        d_opcode = dop; d_source = dsrc; d_denied = dden; d_corrupt = dcor; d_data = ddata;
        d_param = 2'd0; d_size = size;
        d_valid = (d_delay == 0);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 150 && !done; cyc++) begin
            if (a_valid) begin
                obs_a_cycles++;
                if (!a_seen) begin obs_a = cur_a(); a_seen = 1; end
                else if (cur_a() !== obs_a) obs_a_stable = 0;
                if (a_wait >= a_delay) a_ready = 1'b1; else a_wait++;
                if (a_ready) obs_a_beats++;
            end
            if (d_ready && d_delay > 0 && !d_valid) begin
                if (d_wait >= d_delay) d_valid = 1'b1; else d_wait++;
            end
            if (rsp_valid) begin
                cur_r = '{rdata: rsp_rdata, err: rsp_error, tmo: rsp_timeout};
                if (!rsp_seen) begin obs_rsp = cur_r; obs_lat = cyc; rsp_seen = 1; end
                else if (cur_r !== obs_rsp) obs_rsp_stable = 0;
                if (r_wait >= r_delay) begin rsp_ready = 1'b1; done = 1; end else r_wait++;
            end
            @(posedge clk); #1;
        end
        a_ready = 1'b0; d_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] flags;
        logic [31:0] dat;
        repeat (3) @(posedge clk);
        #1;
        flags = {a_valid, d_ready, rsp_valid, rsp_error, rsp_timeout};
        n_cmp++;
        if (flags !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", flags);
        end
        dat = a_address | a_data | rsp_rdata | {25'd0, a_opcode, a_mask};
        n_cmp++;
        if (dat !== 32'd0) begin
            n_fail++; $display("FAIL reset_data_zero: got %h expected 00000000", dat);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_read();
        a_beat_t ea; rsp_t er;
        exp_a_q.push_back('{op: 3'd4, param: 3'd0, size: 2'd2, src: 9'd0,
                            addr: 32'h1000, mask: 4'b1111, data: 32'd0});
        exp_rsp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, tmo: 1'b0});
        txn(1'b0, 32'h1000, 2'd2, 32'h0, 0, 0, 0, 3'd1, 9'd0, 1'b0, 1'b0, 32'hDEADBEEF);
        ea = exp_a_q.pop_front(); er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_a !== ea) begin n_fail++; $display("FAIL read_a_beat: got %h expected %h", obs_a, ea); end
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL read_rsp: got %h expected %h", obs_rsp, er); end
        n_cmp++;
        if (obs_lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", obs_lat); end
        n_cmp++;
        if (obs_a_beats !== 1) begin n_fail++; $display("FAIL read_a_count: got %0d expected 1", obs_a_beats); end
    endtask

    task automatic test_byte_write();
        a_beat_t ea; rsp_t er;
        exp_a_q.push_back('{op: 3'd0, param: 3'd0, size: 2'd0, src: 9'd0,
                            addr: 32'h2003, mask: 4'b1000, data: 32'h000000AB});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        txn(1'b1, 32'h2003, 2'd0, 32'h000000AB, 0, 0, 0, 3'd0, 9'd0, 1'b0, 1'b0, 32'h55555555);
        ea = exp_a_q.pop_front(); er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_a !== ea) begin n_fail++; $display("FAIL bwrite_a_beat: got %h expected %h", obs_a, ea); end
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL bwrite_rsp: got %h expected %h", obs_rsp, er); end
    endtask

    task automatic test_errors();
        rsp_t er;
        // denied read
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b0, 32'h1100, 2'd2, 32'h0, 0, 0, 0, 3'd1, 9'd0, 1'b1, 1'b0, 32'h11223344);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL err_denied: got %h expected %h", obs_rsp, er); end
        // read answered with AccessAck
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b0, 32'h1104, 2'd2, 32'h0, 0, 0, 0, 3'd0, 9'd0, 1'b0, 1'b0, 32'h11223344);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL err_opcode: got %h expected %h", obs_rsp, er); end
        // wrong source
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b0, 32'h1108, 2'd2, 32'h0, 0, 0, 0, 3'd1, 9'd5, 1'b0, 1'b0, 32'h11223344);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL err_source: got %h expected %h", obs_rsp, er); end
        // corrupt write ack
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b1, 32'h110C, 2'd2, 32'h9, 0, 0, 0, 3'd0, 9'd0, 1'b0, 1'b1, 32'h0);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL err_corrupt: got %h expected %h", obs_rsp, er); end
    endtask

    task automatic test_misaligned();
        rsp_t er;
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b0, 32'h1002, 2'd2, 32'h0, 0, 0, 0, 3'd1, 9'd0, 1'b0, 1'b0, 32'hFFFFFFFF);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL misal_rsp: got %h expected %h", obs_rsp, er); end
        n_cmp++;
        if (obs_a_cycles !== 0) begin n_fail++; $display("FAIL misal_no_a: got %0d expected 0", obs_a_cycles); end
        n_cmp++;
        if (obs_lat !== 1) begin n_fail++; $display("FAIL misal_latency: got %0d expected 1", obs_lat); end
        // size 3 is never legal
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b0});
        txn(1'b1, 32'h0, 2'd3, 32'h1234, 0, 0, 0, 3'd0, 9'd0, 1'b0, 1'b0, 32'h0);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er || obs_a_cycles !== 0)
        begin
            n_fail++;
            $display("FAIL misal_size3: got rsp %h a_cycles %0d expected %h and 0", obs_rsp, obs_a_cycles, er);
        end
    endtask

    task automatic test_backpressure();
        a_beat_t ea; rsp_t er;
        exp_a_q.push_back('{op: 3'd0, param: 3'd0, size: 2'd1, src: 9'd0,
                            addr: 32'h4006, mask: 4'b1100, data: 32'hCAFEF00D});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b0, tmo: 1'b0});
        txn(1'b1, 32'h4006, 2'd1, 32'hCAFEF00D, 10, 5, 0, 3'd0, 9'd0, 1'b0, 1'b0, 32'h0);
        ea = exp_a_q.pop_front(); er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_a !== ea) begin n_fail++; $display("FAIL bp_a_beat: got %h expected %h", obs_a, ea); end
        n_cmp++;
        if (obs_a_stable !== 1'b1 || obs_a_cycles !== 11)
        begin
            n_fail++;
            $display("FAIL bp_a_stable: got stable %0d cycles %0d expected 1 and 11", obs_a_stable, obs_a_cycles);
        end
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL bp_rsp: got %h expected %h", obs_rsp, er); end
        n_cmp++;
        if (obs_rsp_stable !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_stable: got %0d expected 1", obs_rsp_stable); end
        n_cmp++;
        if (obs_lat !== 13) begin n_fail++; $display("FAIL bp_latency: got %0d expected 13", obs_lat); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] flags;
        bit bad;
        rsp_t er;
        cmd_write = 1'b0; cmd_addr = 32'h3000; cmd_size = 2'd2; cmd_wdata = 32'd0;
        cmd_valid = 1'b1; a_ready = 1'b1; d_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_dwait: got %b expected 1", d_ready); end
        rst = 1'b1;
        #1;
        flags = {a_valid, d_ready, rsp_valid};
        n_cmp++;
        if (flags !== 3'b000) begin n_fail++; $display("FAIL rstmid_async: got %b expected 000", flags); end
        @(posedge clk); #1;
        rst = 1'b0; a_ready = 1'b0;
        d_valid = 1'b1; d_opcode = 3'd1; d_source = 9'd0; d_denied = 1'b0; d_corrupt = 1'b0;
        d_data = 32'h12345678;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ready || rsp_valid || a_valid) bad = 1;
        end
        d_valid = 1'b0;
        n_cmp++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_d: got %0d expected 0", bad); end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 1", cmd_ready); end
        exp_rsp_q.push_back('{rdata: 32'h0BADF00D, err: 1'b0, tmo: 1'b0});
        txn(1'b0, 32'h3004, 2'd2, 32'h0, 0, 0, 0, 3'd1, 9'd0, 1'b0, 1'b0, 32'h0BADF00D);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL rstmid_recover: got %h expected %h", obs_rsp, er); end
    endtask

    task automatic test_dwait_limit();
        rsp_t er;
`ifdef TL_UL_INITIATOR_TIMEOUT_EN
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1, tmo: 1'b1});
        txn(1'b0, 32'h5000, 2'd2, 32'h0, 0, 0, -1, 3'd1, 9'd0, 1'b0, 1'b0, 32'h77777777);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL timeout_rsp: got %h expected %h", obs_rsp, er); end
        n_cmp++;
        if (obs_lat !== 10) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 10", obs_lat); end
`else
        exp_rsp_q.push_back('{rdata: 32'h77777777, err: 1'b0, tmo: 1'b0});
        txn(1'b0, 32'h5000, 2'd2, 32'h0, 0, 0, 30, 3'd1, 9'd0, 1'b0, 1'b0, 32'h77777777);
        er = exp_rsp_q.pop_front();
        n_cmp++;
        if (obs_rsp !== er) begin n_fail++; $display("FAIL long_wait_rsp: got %h expected %h", obs_rsp, er); end
        n_cmp++;
        if (obs_lat !== 33) begin n_fail++; $display("FAIL long_wait_latency: got %0d expected 33", obs_lat); end
`endif
    endtask

    task automatic test_back_to_back();
        a_beat_t ea; rsp_t er;
        logic wr, dden;
        logic [1:0] size;
        logic [2:0] dop;
        logic [31:0] addr, wdata, ddata;
        for (int i = 0; i < 8; i++) begin
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            addr  = $urandom;
            addr  = addr & ~((32'd1 << size) - 32'd1);
            wdata = $urandom;
            ddata = $urandom;
            dden  = ($urandom_range(0, 3) == 0);
            dop   = wr ? 3'd0 : 3'd1;
            if ($urandom_range(0, 4) == 0) dop = wr ? 3'd1 : 3'd0;
            exp_a_q.push_back(mk_beat(wr, addr, size, wdata));
            exp_rsp_q.push_back(mk_rsp(wr, dop, 9'd0, dden, 1'b0, ddata));
            txn(wr, addr, size, wdata, 0, 0, 0, dop, 9'd0, dden, 1'b0, ddata);
            ea = exp_a_q.pop_front(); er = exp_rsp_q.pop_front();
            n_cmp++;
            if (obs_a !== ea) begin n_fail++; $display("FAIL b2b_a_beat[%0d]: got %h expected %h", i, obs_a, ea); end
            n_cmp++;
            if (obs_rsp !== er) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %h expected %h", i, obs_rsp, er); end
            n_cmp++;
            if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_cmd_ready[%0d]: got %b expected 1", i, cmd_ready); end
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_size = 2'd0; cmd_wdata = 32'd0;
        a_ready = 1'b0;
        d_valid = 1'b0; d_opcode = 3'd0; d_param = 2'd0; d_size = 2'd0; d_source = 9'd0;
        d_denied = 1'b0; d_data = 32'd0; d_corrupt = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_read();
        test_byte_write();
        test_errors();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_dwait_limit();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
